// File: rtl/sd_card_pkg.sv
// Shared encodings, frame lengths and FSM states for the card-side CMD engine.
package sd_card_pkg;

  localparam logic [1:0] RESP_NONE      = 2'd0;
  localparam logic [1:0] RESP_R48       = 2'd1;
  localparam logic [1:0] RESP_R48_NOCRC = 2'd2;
  localparam logic [1:0] RESP_R136      = 2'd3;

  localparam int unsigned CMD_LEN   = 48;
  localparam int unsigned R2_LEN    = 136;
  localparam logic [6:0]  CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    StIdle,
    StRx,
    StWaitResp,
    StWaitNcr,
    StTx,
    StPbit
  } state_e;

endpackage

// File: rtl/sd_card_cmd_resp_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1); shared by command receive and response transmit.
module sd_crc7
  import sd_card_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic fb;
  assign fb = bit_in ^ crc[6];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_card_cmd_resp.sv
// Card-side CMD line engine: receives 48-bit host commands and serialises the
// card's R1/R3/R6/R7 or R2 response back onto the CMD pad.
module sd_card_cmd_resp
  import sd_card_pkg::*;
#(
  parameter int unsigned NCR          = 2,
  parameter int unsigned RESP_TIMEOUT = 64
) (
  input  logic         sd_clk,
  input  logic         rst,
  input  logic         cmd_i,
  output logic         cmd_o,
  output logic         cmd_oe,
  output logic         cmd_valid,
  output logic [5:0]   cmd_idx,
  output logic [31:0]  cmd_arg,
  output logic         cmd_crc_err,
  input  logic         resp_valid,
  output logic         resp_ready,
  input  logic [1:0]   resp_type,
  input  logic [5:0]   resp_idx,
  input  logic [119:0] resp_data,
  output logic         busy
);

  localparam int unsigned TW      = $clog2(RESP_TIMEOUT + 1);
  localparam logic [5:0]  NcrLoad = 6'(NCR - 2);

  state_e         state_q, state_d;
  logic [135:0]   sr_q, sr_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [5:0]     ncr_q, ncr_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           long_q, long_d;
  logic           crc_on_q, crc_on_d;
  logic           valid_d, err_d;
  logic           crc_clr, crc_en, crc_in;
  logic [6:0]     crc;
  logic [7:0]     last_bit, crc_start;
  logic           in_crc_field;

  sd_crc7 u_crc (
    .clk    (sd_clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (crc_in),
    .crc    (crc)
  );

  assign last_bit     = long_q ? 8'(R2_LEN - 1) : 8'(CMD_LEN - 1);
  assign crc_start    = last_bit - 8'd7;
  assign in_crc_field = (cnt_q >= crc_start) && (cnt_q != last_bit);
  assign busy         = (state_q != StIdle);

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ncr_d      = ncr_q;
    tmo_d      = tmo_q;
    long_d     = long_q;
    crc_on_d   = crc_on_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    crc_in     = cmd_i;
    cmd_o      = 1'b1;
    cmd_oe     = 1'b0;
    resp_ready = 1'b0;
    case (state_q)
      StIdle: begin
        if (!cmd_i) begin
          state_d = StRx;
          cnt_d   = 8'd1;
          crc_clr = 1'b1;
          sr_d    = {sr_q[134:0], cmd_i};
        end
      end
      StRx: begin
        sr_d   = {sr_q[134:0], cmd_i};
        cnt_d  = cnt_q + 8'd1;
        crc_en = (cnt_q <= 8'd39);
        if (cnt_q == 8'd1 && !cmd_i) begin
          state_d = StIdle;
        end else if (cnt_q == 8'(CMD_LEN - 1)) begin
          // sr_q[k-1] holds frame bit k here; cmd_i is the end bit
          state_d = StWaitResp;
          tmo_d   = '0;
          valid_d = 1'b1;
          err_d   = (crc != sr_q[6:0]) || !cmd_i;
        end
      end
      StWaitResp: begin
        resp_ready = 1'b1;
        if (resp_valid) begin
          if (resp_type == RESP_NONE) begin
            state_d = StIdle;
          end else begin
            state_d  = StWaitNcr;
            ncr_d    = NcrLoad;
            cnt_d    = '0;
            crc_clr  = 1'b1;
            long_d   = (resp_type == RESP_R136);
            crc_on_d = (resp_type != RESP_R48_NOCRC);
            if (resp_type == RESP_R136) begin
              sr_d = {2'b00, 6'h3F, resp_data, 8'hFF};
            end else begin
              sr_d = {2'b00, (resp_type == RESP_R48) ? resp_idx : 6'h3F, resp_data[31:0],
                      8'hFF, 88'h0};
            end
          end
        end else if (tmo_q == TW'(RESP_TIMEOUT - 1)) begin
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StWaitNcr: begin
        if (ncr_q == 6'd0) begin
          cmd_oe  = 1'b1;
          state_d = StTx;
        end else begin
          ncr_d = ncr_q - 6'd1;
        end
      end
      StTx: begin
        cmd_oe = 1'b1;
        cnt_d  = cnt_q + 8'd1;
        sr_d   = {sr_q[134:0], 1'b0};
        if (crc_on_q && in_crc_field) begin
          // feeding crc[6] back cancels the feedback term, so the register just shifts out
          cmd_o  = crc[6];
          crc_en = 1'b1;
          crc_in = crc[6];
        end else begin
          cmd_o  = sr_q[135];
          crc_in = sr_q[135];
          crc_en = crc_on_q && (cnt_q < crc_start) && (!long_q || cnt_q >= 8'd8);
        end
        if (cnt_q == last_bit) state_d = StPbit;
      end
      StPbit: begin
        cmd_oe  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      cnt_q       <= '0;
      ncr_q       <= '0;
      tmo_q       <= '0;
      long_q      <= 1'b0;
      crc_on_q    <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_idx     <= '0;
      cmd_arg     <= '0;
      cmd_crc_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ncr_q     <= ncr_d;
      tmo_q     <= tmo_d;
      long_q    <= long_d;
      crc_on_q  <= crc_on_d;
      cmd_valid <= valid_d;
      if (valid_d) begin
        cmd_idx     <= sr_q[44:39];
        cmd_arg     <= sr_q[38:7];
        cmd_crc_err <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_sd_card_cmd_resp.sv
// Self-checking bench: table of host frames and card responses, with scoreboard
// queues for received commands and transmitted response frames.
module tb_sd_card_cmd_resp;

  localparam int NCR = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_i;
  logic         cmd_o, cmd_oe, cmd_valid, cmd_crc_err, resp_ready, busy;
  logic [5:0]   cmd_idx;
  logic [31:0]  cmd_arg;
  logic         resp_valid = 1'b0;
  logic [1:0]   resp_type = 2'd0;
  logic [5:0]   resp_idx = 6'd0;
  logic [119:0] resp_data = '0;

  sd_card_cmd_resp #(.NCR(NCR), .RESP_TIMEOUT(64)) dut (
    .sd_clk      (clk),
    .rst         (rst),
    .cmd_i       (cmd_i),
    .cmd_o       (cmd_o),
    .cmd_oe      (cmd_oe),
    .cmd_valid   (cmd_valid),
    .cmd_idx     (cmd_idx),
    .cmd_arg     (cmd_arg),
    .cmd_crc_err (cmd_crc_err),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_type   (resp_type),
    .resp_idx    (resp_idx),
    .resp_data   (resp_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0]  frame;
    logic         exp_valid;
    logic [5:0]   exp_idx;
    logic [31:0]  exp_arg;
    logic         exp_err;
    logic         respond;
    logic [1:0]   rtype;
    logic [5:0]   ridx;
    logic [119:0] rdata;
    logic [135:0] exp_resp;
    logic         use_model;
  } vec_t;

  typedef struct {
    int           len;
    logic [135:0] bits;
    int           start;
  } resp_exp_t;

  vec_t            vecs[8];
  vec_t            cur;
  logic [38:0]     exp_cmd_q[$];
  resp_exp_t       exp_resp_q[$];
  int              cyc = 0;
  int              end_cyc = 0;
  int              passed = 0;
  int              total = 0;
  int              valid_cnt = 0;
  int              resp_cnt = 0;
  int              oe_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  function automatic logic [6:0] crc7(input logic [135:0] v, input int n);
    logic [6:0] c = 7'h00;
    logic       fb;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[6] ^ v[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] f = {2'b01, idx, arg};
    return {f, crc7(136'(f), 40), 1'b1};
  endfunction

  function automatic logic [135:0] build_resp(input logic [1:0] t, input logic [5:0] idx,
                                              input logic [119:0] d);
    logic [135:0] v = '0;
    case (t)
      2'd1: begin
        v[39:0] = {2'b00, idx, d[31:0]};
        v = {v[127:0], crc7(v, 40), 1'b1};
      end
      2'd2: v = {88'h0, 2'b00, 6'h3F, d[31:0], 7'h7F, 1'b1};
      default: begin
        v[127:0] = {2'b00, 6'h3F, d};
        v = {v[127:0], crc7(136'(d), 120), 1'b1};
      end
    endcase
    return v;
  endfunction

  // Card-logic stand-in: answers in the same cycle cmd_valid is seen.
  always @(negedge clk) begin
    resp_exp_t er;
    if (resp_valid) begin
      resp_valid = 1'b0;
    end else if (!rst && cmd_valid && cur.respond) begin
      resp_valid = 1'b1;
      resp_type  = cur.rtype;
      resp_idx   = cur.ridx;
      resp_data  = cur.rdata;
      if (cur.rtype != 2'd0) begin
        er.len   = (cur.rtype == 2'd3) ? 136 : 48;
        er.bits  = cur.use_model ? build_resp(cur.rtype, cur.ridx, cur.rdata) : cur.exp_resp;
        er.start = cyc + NCR;
        exp_resp_q.push_back(er);
      end
    end
  end

  // Output monitor: command scoreboard and CMD-line response capture.
  logic         cap_on = 1'b0;
  int           cap_n = 0;
  int           pb_phase = 0;
  logic [135:0] cap_bits = '0;
  logic         prev_oe = 1'b0, prev_o = 1'b1;

  always @(negedge clk) begin
    resp_exp_t   er;
    logic [38:0] ce;
    if (rst) begin
      if (cap_on) void'(exp_resp_q.pop_front());
      cap_on   = 1'b0;
      pb_phase = 0;
    end else begin
      if (cmd_oe) oe_cycles++;
      if (cmd_valid) begin
        valid_cnt++;
        if (exp_cmd_q.size() == 0) begin
          check("unexpected cmd_valid", 136'(1), 136'(0));
        end else begin
          ce = exp_cmd_q.pop_front();
          check("cmd idx/arg/crc_err", 136'({cmd_idx, cmd_arg, cmd_crc_err}), 136'(ce));
        end
      end
      if (pb_phase == 1) begin
        check("pbit oe/o", 136'({cmd_oe, cmd_o}), 136'(2'b11));
        pb_phase = 2;
      end else if (pb_phase == 2) begin
        check("oe release after pbit", 136'(cmd_oe), 136'(0));
        pb_phase = 0;
      end else if (cap_on) begin
        cap_bits = {cap_bits[134:0], cmd_o};
        cap_n++;
        if (cap_n == exp_resp_q[0].len) begin
          er = exp_resp_q.pop_front();
          check("response frame", cap_bits, er.bits);
          resp_cnt++;
          cap_on   = 1'b0;
          pb_phase = 1;
        end
      end else if (cmd_oe && !cmd_o) begin
        if (exp_resp_q.size() == 0) begin
          check("unexpected response start", 136'(1), 136'(0));
        end else begin
          check("start bit timing", 136'(cyc), 136'(exp_resp_q[0].start));
          check("preamble drive-high", 136'({prev_oe, prev_o}), 136'(2'b11));
          cap_on   = 1'b1;
          cap_n    = 1;
          cap_bits = '0;
        end
      end
    end
    prev_oe = cmd_oe;
    prev_o  = cmd_o;
  end

  task automatic send(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      cmd_i = f[i];
      @(negedge clk);
    end
    cmd_i   = 1'b1;
    end_cyc = cyc;
  endtask

  task automatic apply(input vec_t v);
    int   v0, r0, o0, olen;
    logic rexp;
    cur  = v;
    v0   = valid_cnt;
    r0   = resp_cnt;
    o0   = oe_cycles;
    rexp = v.respond && (v.rtype != 2'd0);
    olen = rexp ? ((v.rtype == 2'd3) ? 138 : 50) : 0;
    if (v.exp_valid) exp_cmd_q.push_back({v.exp_idx, v.exp_arg, v.exp_err});
    send(v.frame);
    for (int k = 0; k < 400 && busy; k++) @(negedge clk);
    check("busy released", 136'(busy), 136'(0));
    repeat (3) @(negedge clk);
    check("cmd_valid count", 136'(valid_cnt - v0), 136'(v.exp_valid));
    check("response count", 136'(resp_cnt - r0), 136'(rexp));
    check("cmd_oe cycle count", 136'(oe_cycles - o0), 136'(olen));
  endtask

  initial begin
    vec_t v;
    int   o0;
    vecs[0] = '{48'h40_0000_0000_95, 1, 6'd0, 32'h0, 0, 1, 2'd0, 6'd0, 120'h0, 136'h0, 0};
    vecs[1] = '{48'h48_0000_01AA_87, 1, 6'd8, 32'h1AA, 0, 1, 2'd1, 6'd8, 120'h1AA,
                136'h08_0000_01AA_13, 0};
    vecs[2] = '{mk_cmd(6'd41, 32'h40FF_8000), 1, 6'd41, 32'h40FF_8000, 0, 1, 2'd2, 6'd41,
                120'h80FF_8000, 136'h3F_80FF_8000_FF, 0};
    vecs[3] = '{48'h51_0000_1000_55, 1, 6'd17, 32'h1000, 1, 1, 2'd0, 6'd0, 120'h0, 136'h0, 0};
    vecs[4] = '{48'h3F_FFFF_FFFF_FF, 0, 6'd0, 32'h0, 0, 0, 2'd0, 6'd0, 120'h0, 136'h0, 0};
    vecs[5] = '{mk_cmd(6'd9, 32'h1234_0000), 1, 6'd9, 32'h1234_0000, 0, 1, 2'd3, 6'd9,
                120'h1, 136'h0, 1};
    vecs[6] = '{mk_cmd(6'd55, 32'hABCD_0000), 1, 6'd55, 32'hABCD_0000, 0, 1, 2'd1, 6'd55,
                120'h0120, 136'h0, 1};
    vecs[7] = '{48'h40_0000_0000_94, 1, 6'd0, 32'h0, 1, 0, 2'd0, 6'd0, 120'h0, 136'h0, 0};

    cur   = vecs[0];
    rst   = 1'b1;
    cmd_i = 1'b1;
    repeat (3) @(negedge clk);
    check("reset outputs",
          136'({cmd_o, cmd_oe, cmd_valid, cmd_idx, cmd_arg, cmd_crc_err, resp_ready, busy}),
          136'({1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0}));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) apply(vecs[i]);

    // No response at all: the wait must end exactly RESP_TIMEOUT cycles after the end bit.
    v = vecs[0];
    v.respond = 1'b0;
    cur = v;
    o0  = oe_cycles;
    exp_cmd_q.push_back({v.exp_idx, v.exp_arg, v.exp_err});
    send(v.frame);
    while (cyc < end_cyc + 63) @(negedge clk);
    check("waiting at timeout-1", 136'({busy, resp_ready}), 136'(2'b11));
    @(negedge clk);
    check("timeout releases", 136'({busy, resp_ready}), 136'(2'b00));
    check("no drive on timeout", 136'(oe_cycles - o0), 136'(0));
    repeat (2) @(negedge clk);

    // Reset in the middle of an R2 transmit.
    cur = vecs[5];
    o0  = oe_cycles;
    exp_cmd_q.push_back({vecs[5].exp_idx, vecs[5].exp_arg, vecs[5].exp_err});
    send(vecs[5].frame);
    for (int k = 0; k < 300 && oe_cycles < o0 + 20; k++) @(negedge clk);
    check("tx under way", 136'(oe_cycles >= o0 + 20), 136'(1));
    rst = 1'b1;
    @(negedge clk);
    check("reset mid-tx", 136'({cmd_o, cmd_oe, busy, resp_ready, cmd_valid}), 136'(5'b10000));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    apply(vecs[0]);

    check("scoreboard drained", 136'(exp_cmd_q.size() + exp_resp_q.size()), 136'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
